// File: rtl/rgb_color_wheel.sv
// Three-channel PWM LED driver: sweeps hue around the 6-sector RGB wheel or holds a loaded static colour.
// Latency: LED outputs are registered one cycle after the PWM counter; duty changes apply at the next period start.
// Backpressure: none; free-running block, the single-cycle load strobe is always accepted.
module rgb_color_wheel #(
    parameter int PWM_INTERVAL = 1200,
    parameter int STEP_CYCLES  = 12000,
    parameter int STEP         = 12,
    parameter int ACTIVE_LOW   = 1,
    localparam int DW          = $clog2(PWM_INTERVAL + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic          load,
    input  logic [DW-1:0] duty_r_in,
    input  logic [DW-1:0] duty_g_in,
    input  logic [DW-1:0] duty_b_in,
    output logic          RGB_R,
    output logic          RGB_G,
    output logic          RGB_B,
    output logic [2:0]    phase,
    output logic          period_start
);

    // Tick counter width; a one-cycle step interval still needs a 1-bit register.
    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [DW-1:0] M         = DW'(PWM_INTERVAL);
    localparam logic [DW:0]   M_EXT     = (DW + 1)'(PWM_INTERVAL);
    localparam logic [DW:0]   STEP_EXT  = (DW + 1)'(STEP);
    localparam logic [DW-1:0] PWM_LAST  = DW'(PWM_INTERVAL - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_CYCLES - 1);
    localparam logic          LED_OFF   = (ACTIVE_LOW != 0);
    localparam logic          LED_ON    = ~LED_OFF;

    logic [DW-1:0] pwm_cnt;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [DW-1:0] ramp;
    logic [DW:0]   ramp_sum;
    logic [DW-1:0] ramp_dn;

    logic [DW-1:0] stat_r, stat_g, stat_b;
    logic [DW-1:0] act_r, act_g, act_b;
    logic [DW-1:0] hue_r, hue_g, hue_b;
    logic [DW-1:0] tgt_r, tgt_g, tgt_b;
    logic [DW-1:0] duty_now_r, duty_now_g, duty_now_b;
    logic          period_zero;

    // Out-of-range static duties saturate to full-on.
    function automatic logic [DW-1:0] clamp_duty(input logic [DW-1:0] v);
        return (v > M) ? M : v;
    endfunction

    assign period_zero = (pwm_cnt == '0);
    assign tick        = (tick_cnt == TICK_LAST);

    // Ramp sum carries one extra bit so ramp+STEP never wraps before the compare.
    assign ramp_sum = {1'b0, ramp} + STEP_EXT;
    assign ramp_dn  = M - ramp;

    // PWM period counter, 0..PWM_INTERVAL-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else if (pwm_cnt == PWM_LAST) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Period start marker, registered so it lines up with the first LED output of the period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_start <= 1'b0;
        end else begin
            period_start <= period_zero;
        end
    end

    // Hue step timer; runs in both modes so the step cadence is unaffected by mode changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Hue engine: advance the ramp on each tick in hue mode, moving to the next sector when it fills.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ramp  <= '0;
            phase <= 3'd0;
        end else if (tick && !mode) begin
            if (ramp_sum >= M_EXT) begin
                ramp  <= '0;
                phase <= (phase == 3'd5) ? 3'd0 : phase + 3'd1;
            end else begin
                ramp <= ramp_sum[DW-1:0];
            end
        end
    end

    // Static colour capture; accepted in either mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_r <= '0;
            stat_g <= '0;
            stat_b <= '0;
        end else if (load) begin
            stat_r <= clamp_duty(duty_r_in);
            stat_g <= clamp_duty(duty_g_in);
            stat_b <= clamp_duty(duty_b_in);
        end
    end

    // Colour wheel: one channel full, one ramping up or down, one off per sector.
    always_comb begin
        hue_r = '0;
        hue_g = '0;
        hue_b = '0;
        case (phase)
            3'd0: begin hue_r = M;       hue_g = ramp;    hue_b = '0;      end
            3'd1: begin hue_r = ramp_dn; hue_g = M;       hue_b = '0;      end
            3'd2: begin hue_r = '0;      hue_g = M;       hue_b = ramp;    end
            3'd3: begin hue_r = '0;      hue_g = ramp_dn; hue_b = M;       end
            3'd4: begin hue_r = ramp;    hue_g = '0;      hue_b = M;       end
            3'd5: begin hue_r = M;       hue_g = '0;      hue_b = ramp_dn; end
            default: begin hue_r = '0;   hue_g = '0;      hue_b = '0;      end
        endcase
    end

    // Target selection follows mode immediately; the period-zero gate below keeps it glitch-free.
    always_comb begin
        tgt_r = mode ? stat_r : hue_r;
        tgt_g = mode ? stat_g : hue_g;
        tgt_b = mode ? stat_b : hue_b;
    end

    // Duty seen by the comparator: the fresh target at count 0 so the new period starts with it.
    always_comb begin
        duty_now_r = period_zero ? tgt_r : act_r;
        duty_now_g = period_zero ? tgt_g : act_g;
        duty_now_b = period_zero ? tgt_b : act_b;
    end

    // Active duties latch only at the period boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_r <= '0;
            act_g <= '0;
            act_b <= '0;
        end else if (period_zero) begin
            act_r <= tgt_r;
            act_g <= tgt_g;
            act_b <= tgt_b;
        end
    end

    // Registered LED drive; reset forces the off level immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RGB_R <= LED_OFF;
            RGB_G <= LED_OFF;
            RGB_B <= LED_OFF;
        end else begin
            RGB_R <= (pwm_cnt < duty_now_r) ? LED_ON : LED_OFF;
            RGB_G <= (pwm_cnt < duty_now_g) ? LED_ON : LED_OFF;
            RGB_B <= (pwm_cnt < duty_now_b) ? LED_ON : LED_OFF;
        end
    end

endmodule

// File: tb/tb_rgb_color_wheel.sv
// Directed bench for rgb_color_wheel: per-period waveform table plus reset and phase-sequence checks.
// Two instances share stimulus: one active-low, one active-high.
// All waits are fixed cycle counts, so the run always terminates.
module tb_rgb_color_wheel;

    localparam int M  = 10;
    localparam int SC = 4;
    localparam int ST = 5;
    localparam int DW = $clog2(M + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic          load;
    logic [DW-1:0] dr, dg, db;
    logic          r1, g1, b1, ps1;
    logic          r2, g2, b2, ps2;
    logic [2:0]    ph1, ph2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rgb_color_wheel #(.PWM_INTERVAL(M), .STEP_CYCLES(SC), .STEP(ST), .ACTIVE_LOW(1)) dut_lo (
        .clk(clk), .rst(rst), .mode(mode), .load(load),
        .duty_r_in(dr), .duty_g_in(dg), .duty_b_in(db),
        .RGB_R(r1), .RGB_G(g1), .RGB_B(b1), .phase(ph1), .period_start(ps1)
    );

    rgb_color_wheel #(.PWM_INTERVAL(M), .STEP_CYCLES(SC), .STEP(ST), .ACTIVE_LOW(0)) dut_hi (
        .clk(clk), .rst(rst), .mode(mode), .load(load),
        .duty_r_in(dr), .duty_g_in(dg), .duty_b_in(db),
        .RGB_R(r2), .RGB_G(g2), .RGB_B(b2), .phase(ph2), .period_start(ps2)
    );

    // Stimulus fields are driven mid-period; expected fields describe the period being measured.
    typedef struct {
        logic mode;
        logic load;
        int   dr, dg, db;
        int   er, eg, eb;
        int   eph;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int on_mask(input int d);
        return (1 << d) - 1;
    endfunction

    // Measure one PWM period (10 samples, bit k = LED on at sample k) and apply the record's stimulus.
    task automatic run_period(input int idx, input vec_t v);
        logic [9:0] pr1, pg1, pb1, pr2, pg2, pb2, pps1, pps2;
        for (int k = 0; k < M; k++) begin
            @(posedge clk);
            @(negedge clk);
            pr1[k]  = (r1 == 1'b0);
            pg1[k]  = (g1 == 1'b0);
            pb1[k]  = (b1 == 1'b0);
            pr2[k]  = (r2 == 1'b1);
            pg2[k]  = (g2 == 1'b1);
            pb2[k]  = (b2 == 1'b1);
            pps1[k] = ps1;
            pps2[k] = ps2;
            if (k == 4) begin
                mode = v.mode;
                load = v.load;
                dr   = DW'(v.dr);
                dg   = DW'(v.dg);
                db   = DW'(v.db);
            end
            if (k == 5) load = 1'b0;
            if (k == M - 1) begin
                check($sformatf("v%0d_phase_lo", idx), int'(ph1), v.eph);
                check($sformatf("v%0d_phase_hi", idx), int'(ph2), v.eph);
            end
        end
        check($sformatf("v%0d_R_lo", idx), int'(pr1), on_mask(v.er));
        check($sformatf("v%0d_G_lo", idx), int'(pg1), on_mask(v.eg));
        check($sformatf("v%0d_B_lo", idx), int'(pb1), on_mask(v.eb));
        check($sformatf("v%0d_R_hi", idx), int'(pr2), on_mask(v.er));
        check($sformatf("v%0d_G_hi", idx), int'(pg2), on_mask(v.eg));
        check($sformatf("v%0d_B_hi", idx), int'(pb2), on_mask(v.eb));
        check($sformatf("v%0d_pstart_lo", idx), int'(pps1), 1);
        check($sformatf("v%0d_pstart_hi", idx), int'(pps2), 1);
    endtask

    initial begin
        logic [9:0] fr, fg, fb;
        int         exp_ph[12];

        // mode load dr dg db | R G B | phase at period end
        vecs[0] = '{1'b0, 1'b0, 0, 0,  0, 10,  0,  0, 1};  // sector 0 ramp 0
        vecs[1] = '{1'b0, 1'b0, 0, 0,  0, 10, 10,  0, 2};  // sector 1 ramp 0
        vecs[2] = '{1'b1, 1'b1, 3, 0, 15,  0, 10,  5, 3};  // sector 2 ramp 5; load+mode mid-period
        vecs[3] = '{1'b1, 1'b1, 7, 2,  4,  3,  0, 10, 3};  // static 3/0/clamped 10; reload mid-period
        vecs[4] = '{1'b0, 1'b0, 0, 0,  0,  7,  2,  4, 3};  // static 7/2/4; back to hue mid-period
        vecs[5] = '{1'b0, 1'b0, 0, 0,  0,  0,  5, 10, 5};  // resumed at sector 3 ramp 5
        vecs[6] = '{1'b0, 1'b0, 0, 0,  0, 10,  0, 10, 0};  // sector 5 ramp 0
        exp_ph = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 0};

        rst  = 1'b1;
        mode = 1'b0;
        load = 1'b0;
        dr   = '0;
        dg   = '0;
        db   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_leds_lo", int'({r1, g1, b1}), 3'b111);
        check("reset_leds_hi", int'({r2, g2, b2}), 3'b000);
        check("reset_phase", int'(ph1), 0);
        check("reset_pstart", int'(ps1), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_period(i, vecs[i]);

        // Reset asserted mid-period while red is lit, in sector 1.
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("prerst_R_on", int'(r1), 0);
        check("prerst_phase", int'(ph1), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_R_lo", int'(r1), 1);
        check("async_rst_R_hi", int'(r2), 0);
        check("async_rst_phase", int'(ph1), 0);
        check("async_rst_pstart", int'(ps1), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // After release: first period red fully on, then the phase walks the wheel once.
        for (int i = 0; i < 48; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i < M) begin
                fr[i] = (r1 == 1'b0);
                fg[i] = (g1 == 1'b0);
                fb[i] = (b1 == 1'b0);
            end
            if (i == 0) check("postrst_pstart", int'(ps1), 1);
            if ((i % SC) == SC - 1)
                check($sformatf("phase_seq_%0d", i / SC), int'(ph1), exp_ph[i / SC]);
        end
        check("postrst_R", int'(fr), on_mask(10));
        check("postrst_G", int'(fg), 0);
        check("postrst_B", int'(fb), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
